// File: rtl/ibex_pkg.sv
// Shared types for the register-file clear controller.
// Holds the sweep FSM state encoding.
package ibex_pkg;

  typedef enum logic {
    RF_CLR_IDLE  = 1'b0,
    RF_CLR_CLEAR = 1'b1
  } rf_clr_state_e;

endpackage

// File: rtl/ibex_rf_clear_ctrl.sv
// Register-file clear sequencer: sweeps registers 1..N-1 to a fixed
// value while letting core writebacks win and protecting what they wrote.
module ibex_rf_clear_ctrl
  import ibex_pkg::*;
#(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_req_i,
  output logic                 clear_busy_o,
  output logic                 clear_done_o,
  input  logic                 core_we_i,
  input  logic [4:0]           core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o
);

  localparam int unsigned NumWords = RV32E ? 16 : 32;
  localparam int unsigned AddrW    = RV32E ? 4 : 5;
  localparam logic [4:0]  LastIdx  = 5'(NumWords - 1);

  rf_clr_state_e         state_q, state_d;
  logic [4:0]            ptr_q, ptr_d;
  logic [NumWords-1:0]   mask_q, mask_d;
  logic                  done_q, done_d;

  logic [AddrW-1:0]      core_idx;
  logic [AddrW-1:0]      ptr_idx;

  // On RV32E the top index bit is dropped so x16..x31 alias x0..x15.
  assign core_idx = core_waddr_i[AddrW-1:0];
  assign ptr_idx  = ptr_q[AddrW-1:0];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mask_d     = mask_q;
    done_d     = 1'b0;
    rf_we_o    = core_we_i;
    rf_waddr_o = core_waddr_i;
    rf_wdata_o = core_wdata_i;
    unique case (state_q)
      RF_CLR_IDLE: begin
        if (clear_req_i) begin
          state_d = RF_CLR_CLEAR;
          ptr_d   = 5'd1;
          mask_d  = '0;
        end
      end
      RF_CLR_CLEAR: begin
        if (core_we_i) begin
          if (core_idx != '0) begin
            mask_d[core_idx] = 1'b1;
          end
        end else begin
          // Skipped slots still consume a cycle so the pointer advances.
          rf_we_o    = ~mask_q[ptr_idx];
          rf_waddr_o = ptr_q;
          rf_wdata_o = WordZeroVal;
          if (ptr_q == LastIdx) begin
            state_d = RF_CLR_IDLE;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 5'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RF_CLR_IDLE;
      ptr_q   <= 5'd1;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

  assign clear_busy_o = (state_q == RF_CLR_CLEAR);
  assign clear_done_o = done_q;

endmodule

// File: tb/tb_ibex_rf_clear_ctrl.sv
// Bench for the register-file clear sequencer, run on a 32-entry
// and a 16-entry instance side by side with a shared stimulus.
module tb_ibex_rf_clear_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  logic        busy0, done0, rwe0;
  logic [4:0]  rwa0;
  logic [31:0] rwd0;
  logic        busy1, done1, rwe1;
  logic [4:0]  rwa1;
  logic [31:0] rwd1;

  always #5 clk = ~clk;

  ibex_rf_clear_ctrl #(
    .RV32E(1'b0),
    .DataWidth(32),
    .WordZeroVal(32'h0)
  ) u_dut0 (
    .clk_i(clk),
    .rst_i(rst),
    .clear_req_i(req),
    .clear_busy_o(busy0),
    .clear_done_o(done0),
    .core_we_i(we),
    .core_waddr_i(waddr),
    .core_wdata_i(wdata),
    .rf_we_o(rwe0),
    .rf_waddr_o(rwa0),
    .rf_wdata_o(rwd0)
  );

  ibex_rf_clear_ctrl #(
    .RV32E(1'b1),
    .DataWidth(32),
    .WordZeroVal(32'hC0DE_0000)
  ) u_dut1 (
    .clk_i(clk),
    .rst_i(rst),
    .clear_req_i(req),
    .clear_busy_o(busy1),
    .clear_done_o(done1),
    .core_we_i(we),
    .core_waddr_i(waddr),
    .core_wdata_i(wdata),
    .rf_we_o(rwe1),
    .rf_waddr_o(rwa1),
    .rf_wdata_o(rwd1)
  );

  logic        o_busy [2];
  logic        o_done [2];
  logic        o_we   [2];
  logic [4:0]  o_wa   [2];
  logic [31:0] o_wd   [2];

  assign o_busy[0] = busy0;
  assign o_busy[1] = busy1;
  assign o_done[0] = done0;
  assign o_done[1] = done1;
  assign o_we[0]   = rwe0;
  assign o_we[1]   = rwe1;
  assign o_wa[0]   = rwa0;
  assign o_wa[1]   = rwa1;
  assign o_wd[0]   = rwd0;
  assign o_wd[1]   = rwd1;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: sweep in progress, next index, protected set.
  bit          m_busy [2];
  int          m_ptr  [2];
  bit          m_skip [2][32];
  bit          m_done [2];
  logic [31:0] exp_mem [2][32];
  logic [31:0] mem     [2][32];
  int          bcnt   [2];

  function automatic int nw(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic logic [31:0] zval(input int k);
    return (k == 0) ? 32'h0 : 32'hC0DE_0000;
  endfunction

  // Register file shadows fed only by the DUT write port.
  always @(posedge clk) begin
    if (rwe0) mem[0][rwa0] = rwd0;
    if (rwe1) mem[1][rwa1] = rwd1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_ptr[k]  = 1;
      m_done[k] = 1'b0;
      for (int i = 0; i < 32; i++) m_skip[k][i] = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit w,
                      input logic [4:0] a,
                      input logic [31:0] d);
    bit          ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    int          idx;
    @(negedge clk);
    req = r; we = w; waddr = a; wdata = d;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!m_busy[k] || w) begin
        ewe = w; ea = a; ed = d;
      end else begin
        ewe = !m_skip[k][m_ptr[k]];
        ea  = 5'(m_ptr[k]);
        ed  = zval(k);
      end
      chk($sformatf("u%0d_busy", k), 32'(o_busy[k]), 32'(m_busy[k]));
      chk($sformatf("u%0d_done", k), 32'(o_done[k]), 32'(m_done[k]));
      chk($sformatf("u%0d_we", k), 32'(o_we[k]), 32'(ewe));
      if (ewe || !m_busy[k] || w) begin
        chk($sformatf("u%0d_waddr", k), 32'(o_wa[k]), 32'(ea));
        chk($sformatf("u%0d_wdata", k), o_wd[k], ed);
      end
      if (o_busy[k]) bcnt[k]++;
      if (ewe) exp_mem[k][ea] = ed;
      m_done[k] = 1'b0;
      if (!m_busy[k]) begin
        if (r) begin
          m_busy[k] = 1'b1;
          m_ptr[k]  = 1;
          for (int i = 0; i < 32; i++) m_skip[k][i] = 1'b0;
        end
      end else if (w) begin
        idx = int'(a) % nw(k);
        if (idx != 0) m_skip[k][idx] = 1'b1;
      end else if (m_ptr[k] == nw(k) - 1) begin
        m_busy[k] = 1'b0;
        m_done[k] = 1'b1;
      end else begin
        m_ptr[k]++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 0; we = 0; waddr = 0; wdata = 0;
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d_rst_busy", k), 32'(o_busy[k]), 32'h0);
      chk($sformatf("u%0d_rst_done", k), 32'(o_done[k]), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 32'h0);
  endtask

  task automatic mem_check(input string tag);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++)
        chk($sformatf("%s_u%0d_r%0d", tag, k, i), mem[k][i], exp_mem[k][i]);
  endtask

  initial begin
    rst = 1'b1; req = 0; we = 0; waddr = 0; wdata = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        mem[k][i] = 32'h0;
        exp_mem[k][i] = 32'h0;
      end
    model_reset();
    do_reset();

    // Idle pass-through.
    step(0, 1, 5'd5, 32'hDEAD_BEEF);
    chk("pt_we", 32'(rwe0), 32'h1);
    chk("pt_waddr", 32'(rwa0), 32'd5);
    chk("pt_wdata", rwd0, 32'hDEAD_BEEF);
    chk("pt_busy", 32'(busy0), 32'h0);

    // Full sweep with no core traffic.
    step(1, 0, 5'd0, 32'h0);
    bcnt[0] = 0; bcnt[1] = 0;
    idle_steps(40);
    chk("len_full_u0", 32'(bcnt[0]), 32'd31);
    chk("len_full_u1", 32'(bcnt[1]), 32'd15);
    mem_check("full");

    // Core writes to x20 while ptr sits at 3.
    step(1, 0, 5'd0, 32'h0);
    bcnt[0] = 0; bcnt[1] = 0;
    idle_steps(2);
    step(0, 1, 5'd20, 32'hAAAA_0001);
    step(0, 1, 5'd20, 32'hAAAA_0002);
    step(0, 0, 5'd0, 32'h0);
    chk("hold_ptr", 32'(rwa0), 32'd3);
    idle_steps(38);
    chk("len_stall_u0", 32'(bcnt[0]), 32'd33);
    chk("len_stall_u1", 32'(bcnt[1]), 32'd17);
    mem_check("stall");

    // Core writes x10 while ptr=4; it must survive the sweep.
    step(1, 0, 5'd0, 32'h0);
    idle_steps(3);
    step(0, 1, 5'd10, 32'h0000_1234);
    idle_steps(40);
    mem_check("skip");
    chk("rb10_u0", mem[0][10], 32'h0000_1234);
    chk("rb10_u1", mem[1][10], 32'h0000_1234);

    // Reset with ptr=12 aborts without a done pulse.
    step(1, 0, 5'd0, 32'h0);
    idle_steps(11);
    chk("pre_rst_ptr", 32'(rwa0), 32'd11);
    do_reset();
    idle_steps(3);
    step(1, 0, 5'd0, 32'h0);
    step(0, 0, 5'd0, 32'h0);
    chk("restart_idx", 32'(rwa0), 32'd1);
    idle_steps(40);

    // Request held high through completion.
    for (int i = 0; i < 40; i++) step(1, 0, 5'd0, 32'h0);
    idle_steps(40);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(7) == 0, $urandom_range(2) == 0,
             5'($urandom), $urandom);
      end
    end
    idle_steps(40);
    mem_check("rand");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
